// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters: lane index sizing.
package stream_pkg;

    localparam int MAX_LANE_IDX_W = 8;

    typedef logic [MAX_LANE_IDX_W-1:0] lane_idx_t;

    // A lane index is at least one bit wide even for a single lane.
    function automatic int lane_idx_w(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lane_select.sv
// Picks the lowest pending lane out of a remaining-keep mask.
module lane_select
    import stream_pkg::*;
#(
    parameter  int RATIO = 2,
    localparam int IDX_W = lane_idx_w(RATIO)
) (
    input  logic [RATIO-1:0] rem,
    output logic [IDX_W-1:0] idx,
    output logic [RATIO-1:0] onehot,
    output logic             single
);

    localparam logic [RATIO-1:0] ONE = RATIO'(1);

    always_comb begin
        idx    = '0;
        onehot = rem & (~rem + ONE);
        single = (rem != '0) && ((rem & (rem - ONE)) == '0);
        // Scan from the top so the lowest set bit wins.
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (rem[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: one beat of T_DATA_RATIO lanes in,
// kept lanes out one word per cycle, lane 0 first.
module stream_downsize
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int IDX_W = lane_idx_w(T_DATA_RATIO);

    logic [T_DATA_WIDTH-1:0] buf_data [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem;
    logic                    buf_last;
    logic                    buf_valid;

    logic [IDX_W-1:0]        lane;
    logic [T_DATA_RATIO-1:0] lane_onehot;
    logic                    rem_single;
    logic                    accept;
    logic                    pop;

    lane_select #(.RATIO(T_DATA_RATIO)) u_lane_select (
        .rem    (rem),
        .idx    (lane),
        .onehot (lane_onehot),
        .single (rem_single)
    );

    // Ready while the final lane drains so beats follow with no bubble.
    assign s_ready_o = !buf_valid || (m_ready_i && rem_single);
    assign accept    = s_valid_i && s_ready_o;
    assign pop       = buf_valid && m_ready_i;

    assign m_valid_o = buf_valid;
    assign m_data_o  = buf_valid ? buf_data[lane] : '0;
    assign m_last_o  = buf_valid && buf_last && rem_single;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < T_DATA_RATIO; i++) buf_data[i] <= '0;
            rem       <= '0;
            buf_last  <= 1'b0;
            buf_valid <= 1'b0;
        end else if (accept) begin
            // An empty-keep beat loads nothing visible and is dropped here.
            for (int i = 0; i < T_DATA_RATIO; i++) buf_data[i] <= s_data_i[i];
            rem       <= s_keep_i;
            buf_last  <= s_last_i;
            buf_valid <= |s_keep_i;
        end else if (pop) begin
            rem <= rem & ~lane_onehot;
            if (rem_single) buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Bench for stream_downsize: vector table, corner sequences, random traffic vs a word-queue model.
module tb_stream_downsize;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] s_data [4];
    logic [3:0] s_keep;
    logic       s_last, s_valid, s_ready;
    logic [7:0] m_data;
    logic       m_last, m_valid, m_ready;

    logic [7:0] s_data2 [2];
    logic [1:0] s_keep2;
    logic       s_last2, s_valid2, s_ready2;
    logic [7:0] m_data2;
    logic       m_last2, m_valid2, m_ready2;

    stream_downsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready)
    );

    stream_downsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data2), .s_keep_i(s_keep2), .s_last_i(s_last2),
        .s_valid_i(s_valid2), .s_ready_o(s_ready2),
        .m_data_o(m_data2), .m_last_o(m_last2), .m_valid_o(m_valid2), .m_ready_i(m_ready2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted beat expands into its kept words.
    typedef struct packed { logic [7:0] d; logic l; } word_t;
    word_t q[$];
    bit    mon_en = 1'b0;
    logic  prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic  prev_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else if (mon_en) begin
            chk("m_valid", m_valid, q.size() != 0);
            chk("s_ready", s_ready, (q.size() == 0) || (m_ready && q.size() == 1));
            if (q.size() != 0) begin
                chk("m_data", m_data, q[0].d);
                chk("m_last", m_last, q[0].l);
            end else begin
                chk("idle_data", m_data, 8'h00);
                chk("idle_last", m_last, 1'b0);
            end
            if (prev_stall) begin
                chk("stall_data", m_data, prev_d);
                chk("stall_last", m_last, prev_l);
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (m_valid && m_ready && q.size() != 0) void'(q.pop_front());
            if (s_valid && s_ready) begin
                int hi;
                hi = -1;
                for (int i = 0; i < 4; i++) if (s_keep[i]) hi = i;
                for (int i = 0; i < 4; i++)
                    if (s_keep[i]) q.push_back('{d: s_data[i], l: s_last && (i == hi)});
            end
        end
    end

    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_t[$];
    int         cyc = 0;

    task automatic clear_got();
        got_d.delete(); got_l.delete(); got_t.delete();
    endtask

    task automatic tick(output logic acc, output logic sr);
        @(negedge clk);
        sr  = s_ready;
        acc = s_valid && s_ready;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data); got_l.push_back(m_last); got_t.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int mr_pct);
        logic a, r;
        for (int i = 0; i < n; i++) begin
            m_ready = ($urandom_range(99) < mr_pct);
            tick(a, r);
        end
    endtask

    task automatic send(input logic [3:0][7:0] d, input logic [3:0] k, input logic l,
                        input int mr_pct, output int acc_cyc);
        logic a, r;
        int   n;
        for (int i = 0; i < 4; i++) s_data[i] = d[i];
        s_keep = k; s_last = l; s_valid = 1'b1;
        a = 1'b0; n = 0; acc_cyc = -1;
        while (!a && n < 200) begin
            m_ready = ($urandom_range(99) < mr_pct);
            acc_cyc = cyc;
            tick(a, r);
            n++;
        end
        if (!a) chk("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [3:0]      keep;
        logic            last;
        int              n;
        logic [3:0][7:0] ed;
        logic [3:0]      el;
    } vec_t;
    vec_t tbl [6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int ac;
        logic a, r;
        int low;
        logic [3:0][7:0] dv;

        tbl[0] = '{d:{8'h44,8'h33,8'h22,8'h11}, keep:4'b1111, last:1'b1, n:4,
                   ed:{8'h44,8'h33,8'h22,8'h11}, el:4'b1000};
        tbl[1] = '{d:{8'hDD,8'hCC,8'hBB,8'hAA}, keep:4'b1010, last:1'b1, n:2,
                   ed:{8'h00,8'h00,8'hDD,8'hBB}, el:4'b0010};
        tbl[2] = '{d:{8'h04,8'h03,8'h02,8'h01}, keep:4'b0001, last:1'b1, n:1,
                   ed:{8'h00,8'h00,8'h00,8'h01}, el:4'b0001};
        tbl[3] = '{d:{8'h08,8'h07,8'h06,8'h05}, keep:4'b1000, last:1'b0, n:1,
                   ed:{8'h00,8'h00,8'h00,8'h08}, el:4'b0000};
        tbl[4] = '{d:{8'h0C,8'h0B,8'h0A,8'h09}, keep:4'b0110, last:1'b1, n:2,
                   ed:{8'h00,8'h00,8'h0B,8'h0A}, el:4'b0010};
        tbl[5] = '{d:{8'hF4,8'hF3,8'hF2,8'hF1}, keep:4'b0000, last:1'b0, n:0,
                   ed:{8'h00,8'h00,8'h00,8'h00}, el:4'b0000};

        for (int i = 0; i < 4; i++) s_data[i] = 8'h00;
        s_keep = '0; s_last = 0; s_valid = 0; m_ready = 1;
        for (int i = 0; i < 2; i++) s_data2[i] = 8'h00;
        s_keep2 = '0; s_last2 = 0; s_valid2 = 0; m_ready2 = 1;

        // reset state
        #12;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst2_m_valid", m_valid2, 1'b0);
        chk("rst2_s_ready", s_ready2, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2, 100);

        // single-beat vectors, m_ready held high
        for (int v = 0; v < 6; v++) begin
            clear_got();
            send(tbl[v].d, tbl[v].keep, tbl[v].last, 100, ac);
            idle(6, 100);
            chk($sformatf("vec%0d_count", v), got_d.size(), tbl[v].n);
            for (int j = 0; j < tbl[v].n && j < got_d.size(); j++) begin
                chk($sformatf("vec%0d_word%0d", v, j), got_d[j], tbl[v].ed[j]);
                chk($sformatf("vec%0d_last%0d", v, j), got_l[j], tbl[v].el[j]);
            end
        end

        // full beat: first word next cycle, s_ready low for 3 cycles
        clear_got();
        send(tbl[0].d, 4'b1111, 1'b1, 100, ac);
        low = 0;
        m_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tick(a, r);
            if (!r) low++;
        end
        chk("full_sready_low", low, 3);
        chk("full_first_latency", got_t.size() > 0 ? got_t[0] - ac : -1, 1);
        chk("full_span", got_t.size() == 4 ? got_t[3] - got_t[0] : -1, 3);

        // back-to-back beats with no idle cycle
        clear_got();
        send(tbl[0].d, 4'b1111, 1'b0, 100, ac);
        dv = {8'h88, 8'h77, 8'h66, 8'h55};
        send(dv, 4'b0011, 1'b1, 100, ac);
        idle(6, 100);
        chk("b2b_count", got_d.size(), 6);
        if (got_d.size() == 6) begin
            chk("b2b_span", got_t[5] - got_t[0], 5);
            chk("b2b_w4", got_d[4], 8'h55);
            chk("b2b_w5", got_d[5], 8'h66);
            chk("b2b_last_w3", got_l[3], 1'b0);
            chk("b2b_last_w5", got_l[5], 1'b1);
        end

        // empty beat between two full beats
        clear_got();
        send(tbl[0].d, 4'b1111, 1'b1, 100, ac);
        send(tbl[5].d, 4'b0000, 1'b0, 100, ac);
        send(tbl[1].d, 4'b1111, 1'b1, 100, ac);
        idle(6, 100);
        chk("empty_count", got_d.size(), 8);
        if (got_d.size() == 8) begin
            chk("empty_span", got_t[7] - got_t[0], 8);
            chk("empty_gap", got_t[4] - got_t[3], 2);
            chk("empty_w4", got_d[4], 8'hAA);
        end

        // reset mid-beat discards the remaining lanes
        clear_got();
        send(tbl[0].d, 4'b1111, 1'b1, 100, ac);
        low = 0;
        while (got_d.size() < 2 && low < 10) begin
            tick(a, r);
            low++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_m_data", m_data, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_s_ready", s_ready, 1'b1);
        idle(6, 100);
        chk("midrst_count", got_d.size(), 2);
        if (got_d.size() >= 2) begin
            chk("midrst_w0", got_d[0], 8'h11);
            chk("midrst_w1", got_d[1], 8'h22);
        end

        // randomized traffic with backpressure, checked by the model
        for (int b = 0; b < 300; b++) begin
            logic [3:0] k;
            k = 4'($urandom_range(15));
            for (int i = 0; i < 4; i++) dv[i] = 8'($urandom_range(255));
            idle($urandom_range(2), 50);
            send(dv, k, (k != 0) ? 1'($urandom_range(1)) : 1'b0, 50, ac);
        end
        idle(12, 100);
        chk("drain_empty", q.size(), 0);

        // two-lane instance: same full-beat case
        s_data2[0] = 8'h11; s_data2[1] = 8'h22; s_keep2 = 2'b11; s_last2 = 1'b1; s_valid2 = 1'b1;
        @(negedge clk);
        chk("r2_s_ready", s_ready2, 1'b1);
        @(posedge clk); #1;
        s_valid2 = 1'b0;
        @(negedge clk);
        chk("r2_v0", m_valid2, 1'b1);
        chk("r2_d0", m_data2, 8'h11);
        chk("r2_l0", m_last2, 1'b0);
        @(negedge clk);
        chk("r2_v1", m_valid2, 1'b1);
        chk("r2_d1", m_data2, 8'h22);
        chk("r2_l1", m_last2, 1'b1);
        @(negedge clk);
        chk("r2_idle", m_valid2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
